// File: rtl/dnn_mac_neuron_pkg.sv
// Shared definitions for the DNN datapath: neuron FSM encoding, default
// data-format constants and the signed saturation limits for a given width.
package dnn_mac_neuron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_ROUND  = 2'd2,
        ST_OUTPUT = 2'd3
    } dnn_state_t;

    localparam int DNN_BITWIDTH  = 8;
    localparam int DNN_FRAC_BITS = 6;

    // Largest value representable in a signed field of the given width.
    function automatic longint dnn_sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    // Smallest value representable in a signed field of the given width.
    function automatic longint dnn_sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/dnn_round_saturate.sv
// Combinational fixed-point narrowing: rounds an accumulator half toward +inf,
// drops FRAC_BITS fractional bits and clamps the result into BITWIDTH signed.
module dnn_round_saturate
    import dnn_mac_neuron_pkg::*;
#(
    parameter int ACC_WIDTH = 21,
    parameter int BITWIDTH  = DNN_BITWIDTH,
    parameter int FRAC_BITS = DNN_FRAC_BITS
) (
    input  logic [ACC_WIDTH-1:0] i_acc,
    output logic [BITWIDTH-1:0]  o_q,
    output logic                 o_ovf
);

    localparam logic signed [ACC_WIDTH-1:0] ACC_HALF =
        ACC_WIDTH'(longint'(1) <<< (FRAC_BITS - 1));
    localparam logic signed [ACC_WIDTH-1:0] ACC_QMAX = ACC_WIDTH'(dnn_sat_max(BITWIDTH));
    localparam logic signed [ACC_WIDTH-1:0] ACC_QMIN = ACC_WIDTH'(dnn_sat_min(BITWIDTH));
    localparam logic [BITWIDTH-1:0]         Q_MAX    = BITWIDTH'(dnn_sat_max(BITWIDTH));
    localparam logic [BITWIDTH-1:0]         Q_MIN    = BITWIDTH'(dnn_sat_min(BITWIDTH));

    logic signed [ACC_WIDTH-1:0] w_biased;
    logic signed [ACC_WIDTH-1:0] w_r;

    // Adding half an LSB before the arithmetic shift gives round-half-up.
    assign w_biased = $signed(i_acc) + ACC_HALF;
    assign w_r      = w_biased >>> FRAC_BITS;

    // Clamp the rounded value into the output range and flag any clipping.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        o_q   = w_r[BITWIDTH-1:0];
        o_ovf = 1'b0;
        if (w_r > ACC_QMAX) begin
            o_q   = Q_MAX;
            o_ovf = 1'b1;
        end else if (w_r < ACC_QMIN) begin
            o_q   = Q_MIN;
            o_ovf = 1'b1;
        end
    end

endmodule

// File: rtl/dnn_mac_neuron.sv
// Single-neuron multiply-accumulate: bias plus NUM_INPUTS streamed X*W
// products, rounded and saturated to BITWIDTH and offered on a valid/ready port.
module dnn_mac_neuron
    import dnn_mac_neuron_pkg::*;
#(
    parameter int BITWIDTH   = DNN_BITWIDTH,
    parameter int NUM_INPUTS = 16,
    parameter int FRAC_BITS  = DNN_FRAC_BITS,
    parameter int ACC_WIDTH  = 2 * BITWIDTH + $clog2(NUM_INPUTS) + 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic [BITWIDTH-1:0] BIAS,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [BITWIDTH-1:0] X,
    input  logic [BITWIDTH-1:0] W,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [BITWIDTH-1:0] Q,
    output logic                OVF,
    output logic                BUSY
);

    localparam int               CNT_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_INPUTS - 1);

    dnn_state_t                  r_state;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic        [CNT_W-1:0]     r_cnt;
    logic        [BITWIDTH-1:0]  r_q;
    logic                        r_ovf;

    logic signed [2*BITWIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]  w_prod_ext;
    logic signed [ACC_WIDTH-1:0]  w_bias_ext;
    logic        [BITWIDTH-1:0]   w_q;
    logic                         w_ovf;

    // Full-precision product and bias, both aligned to the accumulator format.
    assign w_prod     = $signed(X) * $signed(W);
    assign w_prod_ext = ACC_WIDTH'(w_prod);
    assign w_bias_ext = ACC_WIDTH'($signed(BIAS)) <<< FRAC_BITS;

    dnn_round_saturate #(
        .ACC_WIDTH (ACC_WIDTH),
        .BITWIDTH  (BITWIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_round_saturate (
        .i_acc (r_acc),
        .o_q   (w_q),
        .o_ovf (w_ovf)
    );

    assign IN_READY  = (r_state == ST_ACCUM);
    assign OUT_VALID = (r_state == ST_OUTPUT);
    assign BUSY      = (r_state != ST_IDLE);
    assign Q         = r_q;
    assign OVF       = r_ovf;

    // Evaluation sequencer: load bias, accumulate beats, round once, hold result.
    always_ff @(posedge CLK) begin
        // NOTE: state uses <= so every register here samples pre-edge values.
        if (RST) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_acc   <= w_bias_ext;
                        r_cnt   <= '0;
                        r_state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (IN_VALID) begin
                        r_acc <= r_acc + w_prod_ext;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == LAST_BEAT) begin
                            r_state <= ST_ROUND;
                        end
                    end
                end
                ST_ROUND: begin
                    r_q     <= w_q;
                    r_ovf   <= w_ovf;
                    r_state <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (OUT_READY) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dnn_mac_neuron.sv
// Self-checking bench for dnn_mac_neuron: directed and randomized evaluations
// scored against an arithmetic model of the neuron, with protocol checks.
module tb_dnn_mac_neuron;

    localparam int BW = 8;
    localparam int N  = 16;
    localparam int FB = 6;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic [BW-1:0] BIAS;
    logic          IN_VALID;
    logic          IN_READY;
    logic [BW-1:0] X;
    logic [BW-1:0] W;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [BW-1:0] Q;
    logic          OVF;
    logic          BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    int bx [N];
    int bw [N];

    typedef struct {
        int q;
        int ovf;
    } exp_t;

    exp_t exp_q [$];

    always #5 CLK = ~CLK;

    dnn_mac_neuron #(
        .BITWIDTH   (BW),
        .NUM_INPUTS (N),
        .FRAC_BITS  (FB)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .BIAS      (BIAS),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .X         (X),
        .W         (W),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .Q         (Q),
        .OVF       (OVF),
        .BUSY      (BUSY)
    );

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    // Neuron result straight from the arithmetic definition: exact sum,
    // round half toward +inf via floor division, then clamp to the output range.
    function automatic exp_t model(input int bias);
        longint sum;
        longint r;
        longint quo;
        longint one;
        exp_t   e;
        one = 2 ** FB;
        sum = longint'(bias) * one;
        for (int i = 0; i < N; i++) sum += longint'(bx[i]) * longint'(bw[i]);
        r   = sum + one / 2;
        quo = r / one;
        if (r < 0 && (r % one) != 0) quo -= 1;
        if (quo > 127) begin
            e.q = 127;  e.ovf = 1;
        end else if (quo < -128) begin
            e.q = -128; e.ovf = 1;
        end else begin
            e.q = int'(quo); e.ovf = 0;
        end
        return e;
    endfunction

    // Output scoreboard: every cycle with OUT_VALID must present the oldest
    // pending result; the entry retires on the cycle the handshake completes.
    always @(negedge CLK) begin
        if (RST === 1'b0 && OUT_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'(OUT_VALID), 0);
            end else begin
                check("q", $signed(Q), exp_q[0].q);
                check("ovf", 32'(OVF), exp_q[0].ovf);
                if (OUT_READY === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    task automatic clear_beats();
        for (int i = 0; i < N; i++) begin
            bx[i] = 0;
            bw[i] = 0;
        end
    endtask

    // One evaluation. Entered with the DUT idle; leaves it idle at a negedge.
    task automatic run_eval(input int bias, input int valid_pct, input int hold,
                            input bit noise, input bit pin, input int pin_q, input int pin_ovf);
        exp_t e;
        int   beat;
        int   cyc;
        bit   took;
        e = model(bias);
        if (pin) begin
            check("model_q", e.q, pin_q);
            check("model_ovf", e.ovf, pin_ovf);
        end
        exp_q.push_back(e);
        START = 1'b1;
        BIAS  = BW'(bias);
        @(posedge CLK); #1;
        START = 1'b0;
        beat  = 0;
        cyc   = 0;
        while (beat < N && cyc < 2000) begin
            IN_VALID = ($urandom_range(99) < valid_pct);
            X = BW'(bx[beat]);
            W = BW'(bw[beat]);
            if (noise) begin
                START = 1'($urandom_range(1));
                BIAS  = BW'($urandom);
            end
            @(negedge CLK);
            took = IN_VALID && IN_READY;
            check("accum_in_ready", 32'(IN_READY), 1);
            @(posedge CLK); #1;
            if (took) beat++;
            cyc++;
        end
        check("beats_accepted", beat, N);
        // Round cycle: a junk beat is offered and must not be taken.
        IN_VALID = 1'b1;
        X = BW'($urandom);
        W = BW'($urandom);
        START = noise;
        @(negedge CLK);
        check("round_in_ready", 32'(IN_READY), 0);
        check("round_out_valid", 32'(OUT_VALID), 0);
        OUT_READY = (hold == 0);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("latency_out_valid", 32'(OUT_VALID), 1);
        check("output_in_ready", 32'(IN_READY), 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge CLK); #1;
            OUT_READY = (h == hold - 1);
            START = noise;
            @(negedge CLK);
            check("hold_out_valid", 32'(OUT_VALID), 1);
            check("hold_in_ready", 32'(IN_READY), 0);
        end
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        START     = 1'b0;
        IN_VALID  = 1'b0;
        @(negedge CLK);
        check("idle_busy", 32'(BUSY), 0);
        check("idle_out_valid", 32'(OUT_VALID), 0);
    endtask

    // Start an evaluation, feed seven beats, then reset mid-accumulation.
    task automatic reset_mid();
        START = 1'b1;
        BIAS  = BW'($urandom);
        @(posedge CLK); #1;
        START    = 1'b0;
        IN_VALID = 1'b1;
        for (int i = 0; i < 7; i++) begin
            X = BW'($urandom);
            W = BW'($urandom);
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST      = 1'b0;
        IN_VALID = 1'b0;
        @(negedge CLK);
        check("rst_in_ready", 32'(IN_READY), 0);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_out_valid", 32'(OUT_VALID), 0);
        check("rst_q", $signed(Q), 0);
        check("rst_ovf", 32'(OVF), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        RST       = 1'b1;
        START     = 1'b0;
        BIAS      = '0;
        IN_VALID  = 1'b0;
        X         = '0;
        W         = '0;
        OUT_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("reset_q", $signed(Q), 0);
        check("reset_ovf", 32'(OVF), 0);
        check("reset_out_valid", 32'(OUT_VALID), 0);
        check("reset_in_ready", 32'(IN_READY), 0);
        check("reset_busy", 32'(BUSY), 0);

        // Bias only.
        clear_beats();
        run_eval(10, 100, 0, 1'b0, 1'b1, 10, 0);

        // Rounding at the half-LSB boundary, both signs.
        clear_beats(); bx[0] = 1;  bw[0] = 32;
        run_eval(0, 100, 0, 1'b0, 1'b1, 1, 0);
        bw[0] = 31;
        run_eval(0, 100, 0, 1'b0, 1'b1, 0, 0);
        bx[0] = -1; bw[0] = 32;
        run_eval(0, 100, 0, 1'b0, 1'b1, 0, 0);
        bw[0] = 33;
        run_eval(0, 100, 0, 1'b0, 1'b1, -1, 0);

        // Saturation in both directions.
        for (int i = 0; i < N; i++) begin bx[i] = 64;  bw[i] = 64; end
        run_eval(0, 100, 0, 1'b0, 1'b1, 127, 1);
        for (int i = 0; i < N; i++) bx[i] = -64;
        run_eval(0, 100, 0, 1'b0, 1'b1, -128, 1);

        // Normal value with input and output backpressure.
        clear_beats(); bx[5] = 32; bw[5] = 64;
        run_eval(0, 50, 5, 1'b0, 1'b1, 32, 0);

        // START and BIAS noise while busy must not disturb the evaluation.
        clear_beats();
        run_eval(-3, 70, 2, 1'b1, 1'b1, -3, 0);
        for (int i = 0; i < N; i++) begin
            bx[i] = int'($urandom_range(31)) - 16;
            bw[i] = int'($urandom_range(31)) - 16;
        end
        run_eval(int'($urandom_range(255)) - 128, 60, 3, 1'b1, 1'b0, 0, 0);

        // Abort mid-run, then a clean evaluation with no residue.
        reset_mid();
        clear_beats();
        run_eval(5, 100, 0, 1'b0, 1'b1, 5, 0);

        // Randomized back-to-back evaluations, small and full-range operands.
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N; i++) begin
                if (t % 2 == 0) begin
                    bx[i] = int'($urandom_range(15)) - 8;
                    bw[i] = int'($urandom_range(31)) - 16;
                end else begin
                    bx[i] = int'($urandom_range(255)) - 128;
                    bw[i] = int'($urandom_range(255)) - 128;
                end
            end
            run_eval(int'($urandom_range(255)) - 128, int'($urandom_range(100, 30)),
                     int'($urandom_range(3)), 1'($urandom_range(1)), 1'b0, 0, 0);
        end

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
